// File: rtl/lfsr_prbs.sv
// lfsr_prbs: Fibonacci LFSR pattern generator with an optional
// self-synchronising readback checker (one clock domain).
// Build option: define LFSR_PRBS_CHECKER_EN to build the checker. Without it,
// chk_locked/chk_err/err_count are tied to zero and the chk_* inputs are ignored.
module lfsr_prbs #(
  parameter int                 WIDTH        = 22,
  parameter logic [WIDTH-1:0]   TAPS         = WIDTH'(22'h300000),
  parameter logic [WIDTH-1:0]   SEED         = WIDTH'(4),
  parameter int                 LOCK_COUNT   = 4,
  parameter int                 UNLOCK_COUNT = 8,
  parameter int                 ERR_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  input  logic             chk_clear,
  output logic             chk_locked,
  output logic             chk_err,
  output logic [ERR_W-1:0] err_count
);

  // One LFSR step; the all-zero lockup state recovers to SEED.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    if (x == '0) step = SEED;
    else         step = {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Generator next state: load beats ena; a zero load value is replaced by SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)     lfsr_d = (seed_in == '0) ? SEED : seed_in;
    else if (ena) lfsr_d = step(lfsr_q);
  end

  // Generator state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

`ifdef LFSR_PRBS_CHECKER_EN
  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [7:0]       match_inc, miss_inc;

  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  // Checker next state: HUNT reseeds the replica from the data stream,
  // LOCKED free-runs the replica so bad words cannot pull it off sequence.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (chk_valid) begin
      case (state_q)
        HUNT: begin
          exp_d = step(chk_data);
          if (chk_data == exp_q && chk_data != '0) begin
            if (match_inc == 8'(LOCK_COUNT)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          exp_d = step(exp_q);
          if (chk_data == exp_q) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_W'(1);
            if (miss_inc == 8'(UNLOCK_COUNT)) begin
              state_d = HUNT;
              match_d = '0;
              miss_d  = '0;
              exp_d   = step(chk_data);
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Clear wins over a coincident increment; lock state is untouched.
    if (chk_clear) cnt_d = '0;
    locked_d = (state_d == LOCKED);
  end

  // Checker state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign chk_locked = locked_q;
  assign chk_err    = err_q;
  assign err_count  = cnt_q;
`else
  logic unused_chk;
  assign unused_chk = ^{chk_valid, chk_data, chk_clear};
  assign chk_locked = 1'b0;
  assign chk_err    = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: doc/lfsr_prbs.md
Name: lfsr_prbs

Overview:
- Parametrised Fibonacci LFSR pattern generator plus optional self-synchronising checker, both in one clock domain.
- Used by the SDRAM test project and other memory/bus soak tests.
- Generator produces the write pattern.
- Checker compares readback words against a replica LFSR, tracks lock status and counts mismatches.

Parameters:
- WIDTH, 22: LFSR width in bits; legal range 4..32.
- TAPS, 22'h300000: feedback tap mask, bit i set means state bit i is XORed into feedback. The default gives x^22+x^21+1.
- SEED, 4: reset value, also used as the lockup-recovery value; must be non-zero.
- LOCK_COUNT, 4: consecutive matching words required to declare lock; range 1..255.
- UNLOCK_COUNT, 8: consecutive mismatches in LOCKED that force a return to HUNT; range 1..255.
- ERR_W, 16: width of the error counter.

Ports:
- clk, input, 1: clock, rising-edge.
- reset_n, input, 1: asynchronous active-low reset.
- ena, input, 1: advance the generator one step.
- load, input, 1: load the generator from seed_in.
- seed_in, input, WIDTH: value for load.
- lfsr, output, WIDTH: generator state.
- chk_valid, input, 1: chk_data is valid this cycle.
- chk_data, input, WIDTH: readback word.
- chk_clear, input, 1: clear err_count.
- chk_locked, output, 1: checker is in LOCKED.
- chk_err, output, 1: one-cycle pulse on a counted mismatch.
- err_count, output, ERR_W: saturating mismatch count.

Behaviour:
- Reset (async assert, sync release): lfsr=SEED, checker state=HUNT, expected=0, match_cnt=0, miss_cnt=0, chk_locked=0, chk_err=0, err_count=0.
- step(x) = {x[WIDTH-2:0], ^(x & TAPS)}; if x==0 then step(x)=SEED (lockup recovery).
- Generator priority per cycle: load > ena > hold.
  - load=1: lfsr<=seed_in. If seed_in==0, lfsr<=SEED instead.
  - ena=1, load=0: lfsr<=step(lfsr).
  - Result is visible the cycle after the strobe.
- Checker register expected holds the predicted next readback word. Only chk_valid cycles are evaluated; all other cycles hold state, and chk_err=0.
- HUNT state:
  - expected<=step(chk_data) every valid cycle (reseed from data).
  - chk_data==expected and chk_data!=0: match_cnt+1. On reaching LOCK_COUNT, go to LOCKED with match_cnt=0 and miss_cnt=0.
  - Otherwise match_cnt=0.
  - No errors are counted in HUNT.
- LOCKED state:
  - expected<=step(expected) every valid cycle (free-running replica, not reseeded).
  - Match: miss_cnt=0.
  - Mismatch: chk_err=1 next cycle, err_count+1 (saturates at all-ones), miss_cnt+1.
  - When miss_cnt reaches UNLOCK_COUNT: go to HUNT, match_cnt=0, and expected<=step(chk_data).
- chk_locked is registered; it equals (state==LOCKED) and changes on the cycle after the transition-causing valid word.
- chk_clear:
  - err_count<=0.
  - If a counted mismatch occurs in the same cycle, the clear wins and err_count=0; chk_err still pulses.
  - chk_clear does not affect lock state.
- Generator and checker are independent: no shared state, so simultaneous ena/load/chk_valid are all legal.
- Mid-operation reset returns every register to its reset value immediately.
- Sequence period with default TAPS: 2^22-1.

Optional Feature:
- Macro LFSR_PRBS_CHECKER_EN.
- Defined: checker logic as described.
- Undefined: no checker registers are built; chk_locked=0, chk_err=0, err_count=0 constant; chk_* inputs are ignored. Generator behaviour is identical in both builds.

Test Plan:
- Reset release with defaults, 1 ena pulse -> lfsr=22'h000008. After 18 total steps -> 22'h100000; next step -> 22'h200001.
- load=1, seed_in=0 with ena=1 in the same cycle -> lfsr=SEED (4), not step(0) and not 0. Then load seed_in=22'h3FFFFF -> lfsr=22'h3FFFFF; next ena -> 22'h3FFFFE.
- Feed generator output into chk_data each cycle from lfsr=4 -> chk_locked rises on the cycle after the 5th valid word (LOCK_COUNT=4); err_count stays 0.
- While locked, flip bit 0 of one word -> exactly one chk_err pulse and err_count=1; lock is held; the next correct words match (the replica has not resynchronised onto bad data).
- While locked, drive 8 consecutive constant 22'h0 words -> err_count=8 and chk_locked falls. Resume the valid sequence -> relock after 5 words.
- ERR_W=4, locked, 20 mismatches with UNLOCK_COUNT=255 -> err_count saturates at 15. chk_clear coincident with a mismatch -> err_count=0 and chk_err=1. Build without LFSR_PRBS_CHECKER_EN -> all checker outputs 0.
